// File: rtl/bcd_timer_pkg.sv
// Shared encodings for the BCD stopwatch: FSM states and display digit-select codes.
// The segment output stage imports this package as well.
package bcd_timer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    localparam logic [1:0] SEL_TIM1 = 2'b00;
    localparam logic [1:0] SEL_TIM2 = 2'b01;
    localparam logic [1:0] SEL_TIM3 = 2'b10;

    // Scan order TIM1 -> TIM2 -> TIM3 -> TIM1; the unused code 11 recovers to TIM1.
    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        case (sel)
            SEL_TIM1: return SEL_TIM2;
            SEL_TIM2: return SEL_TIM3;
            default:  return SEL_TIM1;
        endcase
    endfunction

    function automatic logic [2:0] dig_en_decode(input logic [1:0] sel);
        case (sel)
            SEL_TIM1: return 3'b110;
            SEL_TIM2: return 3'b101;
            SEL_TIM3: return 3'b011;
            default:  return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// Control pulses and display outputs of the BCD stopwatch.
interface bcd_timer_if;
    import bcd_timer_pkg::*;

    logic       start_stop;
    logic       clear;
    logic [3:0] tim_1;
    logic [3:0] tim_2;
    logic [3:0] tim_3;
    logic [1:0] oe_digit;
    logic [2:0] dig_en;
    logic       running;
    logic       ovf;

    modport master (
        output start_stop, clear,
        input  tim_1, tim_2, tim_3, oe_digit, dig_en, running, ovf
    );

    modport slave (
        input  start_stop, clear,
        output tim_1, tim_2, tim_3, oe_digit, dig_en, running, ovf
    );

endinterface

// File: rtl/bcd_timer_digit.sv
// One BCD decade: counts 0..9 on carry-in and ripples a combinational carry-out on 9->0.
module bcd_digit (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_cin,
    output logic [3:0] o_q,
    output logic       o_cout
);

    logic [3:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 4'd0;
        end else if (i_clr) begin
            r_q <= 4'd0;
        end else if (i_cin) begin
            // >= rather than == so an out-of-range value can never persist
            r_q <= (r_q >= 4'd9) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign o_q    = r_q;
    assign o_cout = i_cin && (r_q == 4'd9);

endmodule

// File: rtl/bcd_timer.sv
// Three-digit BCD stopwatch with run/pause/clear control and a multiplexed digit scan.
//   state    | meaning
//   ST_IDLE  | cleared, prescaler held at zero, waiting for START_STOP
//   ST_RUN   | prescaler counting, digits advance on each tick
//   ST_PAUSE | prescaler and digits frozen, partial count kept
module bcd_timer
    import bcd_timer_pkg::*;
#(
    parameter int PRESCALE = 5000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    bcd_timer_if.slave  tif
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_running;
    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_scan;
    logic [1:0]    r_oe;
    logic [2:0]    r_dig_en;
    logic          r_ovf;
    logic          w_tick;
    logic          w_c1;
    logic          w_c2;
    logic          w_c3;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (tif.start_stop) w_state_nxt = ST_RUN;
            ST_RUN:   if (tif.start_stop) w_state_nxt = ST_PAUSE;
            ST_PAUSE: if (tif.start_stop) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (tif.clear) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    // A clear in the tick cycle suppresses the tick so the digits land on zero.
    assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !tif.clear;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_presc <= '0;
        end else if (tif.clear) begin
            r_presc <= '0;
        end else begin
            case (r_state)
                ST_RUN:   r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
                ST_PAUSE: r_presc <= r_presc;
                default:  r_presc <= '0;
            endcase
        end
    end

    bcd_digit u_dig1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (tif.clear),
        .i_cin  (w_tick),
        .o_q    (tif.tim_1),
        .o_cout (w_c1)
    );

    bcd_digit u_dig2 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (tif.clear),
        .i_cin  (w_c1),
        .o_q    (tif.tim_2),
        .o_cout (w_c2)
    );

    bcd_digit u_dig3 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (tif.clear),
        .i_cin  (w_c2),
        .o_q    (tif.tim_3),
        .o_cout (w_c3)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (tif.clear) begin
            r_ovf <= 1'b0;
        end else if (w_c3) begin
            r_ovf <= 1'b1;
        end
    end

    // Display scan is free-running; only reset touches it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scan   <= '0;
            r_oe     <= SEL_TIM1;
            r_dig_en <= 3'b110;
        end else if (r_scan >= SCAN_LAST) begin
            r_scan   <= '0;
            r_oe     <= next_sel(r_oe);
            r_dig_en <= dig_en_decode(next_sel(r_oe));
        end else begin
            r_scan   <= r_scan + SW'(1);
        end
    end

    assign tif.running  = r_running;
    assign tif.ovf      = r_ovf;
    assign tif.oe_digit = r_oe;
    assign tif.dig_en   = r_dig_en;

endmodule

// File: tb/tb_bcd_timer.sv
// Directed bench for bcd_timer with PRESCALE=4, SCAN_DIV=2; expected values are hand-derived.
module tb_bcd_timer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bcd_timer_if tif ();

    bcd_timer #(
        .PRESCALE (4),
        .SCAN_DIV (2)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .tif   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ss();
        tif.start_stop = 1'b1;
        step(1);
        tif.start_stop = 1'b0;
    endtask

    task automatic check_digits(input string tag, input logic [3:0] d3, d2, d1);
        check({tag, "_tim3"}, 32'(tif.tim_3), 32'(d3));
        check({tag, "_tim2"}, 32'(tif.tim_2), 32'(d2));
        check({tag, "_tim1"}, 32'(tif.tim_1), 32'(d1));
    endtask

    function automatic logic [2:0] exp_dig_en(input logic [1:0] sel);
        case (sel)
            2'b00:   return 3'b110;
            2'b01:   return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    initial begin
        logic range_bad;
        logic [1:0] exp_oe;
        n_checks = 0;
        n_errors = 0;
        tif.start_stop = 1'b0;
        tif.clear      = 1'b0;
        rst = 1'b1;
        step(2);

        check_digits("rst", 4'd0, 4'd0, 4'd0);
        check("rst_oe", 32'(tif.oe_digit), 32'd0);
        check("rst_dig_en", 32'(tif.dig_en), 32'b110);
        check("rst_running", 32'(tif.running), 32'd0);
        check("rst_ovf", 32'(tif.ovf), 32'd0);
        rst = 1'b0;
        step(3);
        check("idle_no_count", 32'(tif.tim_1), 32'd0);

        // start: RUNNING next cycle, first tick 4 cycles later
        pulse_ss();
        check("start_running", 32'(tif.running), 32'd1);
        step(3);
        check("pre_tick1", 32'(tif.tim_1), 32'd0);
        step(1);
        check("tick1", 32'(tif.tim_1), 32'd1);
        step(4);
        check("tick2", 32'(tif.tim_1), 32'd2);

        // carry 9 -> 10, then run to 40 ticks
        step(7 * 4);
        check_digits("nine", 4'd0, 4'd0, 4'd9);
        step(4);
        check_digits("ten", 4'd0, 4'd1, 4'd0);
        range_bad = 1'b0;
        for (int i = 0; i < 30 * 4; i++) begin
            step(1);
            if (tif.tim_1 > 4'd9 || tif.tim_2 > 4'd9 || tif.tim_3 > 4'd9) range_bad = 1'b1;
        end
        check("digit_range", 32'(range_bad), 32'd0);
        check_digits("forty", 4'd0, 4'd4, 4'd0);

        // pause after 2 prescaler cycles, resume, tick 2 cycles later
        step(1);
        pulse_ss();
        check("pause_running", 32'(tif.running), 32'd0);
        step(20);
        check_digits("paused", 4'd0, 4'd4, 4'd0);
        pulse_ss();
        check("resume_running", 32'(tif.running), 32'd1);
        step(1);
        check("resume_pre_tick", 32'(tif.tim_1), 32'd0);
        step(1);
        check("resume_tick", 32'(tif.tim_1), 32'd1);

        // preload 041 -> 998, then wrap
        step(957 * 4);
        check_digits("pre998", 4'd9, 4'd9, 4'd8);
        check("pre998_ovf", 32'(tif.ovf), 32'd0);
        step(8);
        check_digits("wrap", 4'd0, 4'd0, 4'd0);
        check("wrap_ovf", 32'(tif.ovf), 32'd1);
        step(4);
        check("after_wrap_tim1", 32'(tif.tim_1), 32'd1);
        check("ovf_sticky", 32'(tif.ovf), 32'd1);
        tif.clear = 1'b1;
        step(1);
        tif.clear = 1'b0;
        check("clr_ovf", 32'(tif.ovf), 32'd0);
        check("clr_running", 32'(tif.running), 32'd0);
        check_digits("clr", 4'd0, 4'd0, 4'd0);
        step(8);
        check("clr_idle_hold", 32'(tif.tim_1), 32'd0);

        // clear and start_stop together while running: clear wins
        pulse_ss();
        step(4);
        check("cs_pre_tim1", 32'(tif.tim_1), 32'd1);
        tif.clear = 1'b1;
        tif.start_stop = 1'b1;
        step(1);
        tif.clear = 1'b0;
        tif.start_stop = 1'b0;
        check("cs_running", 32'(tif.running), 32'd0);
        check_digits("cs", 4'd0, 4'd0, 4'd0);
        step(8);
        check("cs_idle_tim1", 32'(tif.tim_1), 32'd0);
        pulse_ss();
        check("cs_restart", 32'(tif.running), 32'd1);

        // reset mid-run abandons the pending tick
        step(2);
        #2 rst = 1'b1;
        #1;
        check("rst_run_running", 32'(tif.running), 32'd0);
        step(1);
        rst = 1'b0;
        step(8);
        check("rst_run_tim1", 32'(tif.tim_1), 32'd0);
        check("rst_run_idle", 32'(tif.running), 32'd0);

        // scan sequence from a fresh reset
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            exp_oe = 2'((k / 2) % 3);
            check($sformatf("scan_oe_%0d", k), 32'(tif.oe_digit), 32'(exp_oe));
            check($sformatf("scan_en_%0d", k), 32'(tif.dig_en), 32'(exp_dig_en(exp_oe)));
        end
        step(4);
        check("scan_mid_oe", 32'(tif.oe_digit), 32'd2);
        #3 rst = 1'b1;
        #1;
        check("scan_rst_oe", 32'(tif.oe_digit), 32'd0);
        check("scan_rst_en", 32'(tif.dig_en), 32'b110);
        step(1);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer.md
BCD_TIMER -- requirements
Module: bcd_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 5000000, CLK cycles per count tick (must be >=2).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, CLK cycles per display-digit scan step (must be >=2).
REQ-003 CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 START_STOP  input  1  single-cycle synchronous pulse, already debounced; toggles run/pause.
REQ-006 CLEAR  input  1  single-cycle synchronous pulse; zeroes the count and returns to idle.
REQ-007 TIM_1  output  4  BCD units digit, registered.
REQ-008 TIM_2  output  4  BCD tens digit, registered.
REQ-009 TIM_3  output  4  BCD hundreds digit, registered.
REQ-010 OE_DIGIT  output  2  digit-select code for the segment stage: 00=TIM_1, 01=TIM_2, 10=TIM_3.
REQ-011 DIG_EN  output  3  active-low one-hot digit anode enable matching OE_DIGIT (00->110, 01->101, 10->011).
REQ-012 RUNNING  output  1  high while in state RUN.
REQ-013 OVF  output  1  sticky flag, set on wrap 999->000.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE.
REQ-015 Transitions: IDLE+START_STOP->RUN; RUN+START_STOP->PAUSE; PAUSE+START_STOP->RUN; CLEAR in any state->IDLE.
REQ-016 CLEAR and START_STOP asserted in the same cycle: CLEAR SHALL win; START_STOP ignored.
REQ-017 CLEAR SHALL zero TIM_1..3, prescaler and OVF on the following edge.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 only in RUN, hold its value in PAUSE, be zero in IDLE.
REQ-019 Tick SHALL be the cycle in RUN with prescaler==PRESCALE-1; prescaler wraps to 0 on that edge.
REQ-020 On tick, digits SHALL increment as a 3-digit BCD counter on the same edge; each digit wraps 9->0 with carry to the next.
REQ-021 On tick at 999, digits SHALL become 000 and OVF SHALL set; counting continues; OVF stays set until CLEAR or RST.
REQ-022 Digits SHALL never hold a value above 9.
REQ-023 Pause/resume SHALL not lose the partial prescaler count: first tick after resume occurs PRESCALE minus already-counted cycles later.
REQ-024 START_STOP effect on RUNNING SHALL be visible one cycle after the pulse.
REQ-025 Scan counter SHALL count 0..SCAN_DIV-1 in every state, independent of RUN/PAUSE/CLEAR.
REQ-026 At scan terminal count OE_DIGIT SHALL advance 00->01->10->00; code 11 SHALL never be driven.
REQ-027 DIG_EN SHALL be a registered decode changing on the same edge as OE_DIGIT.

Reset
REQ-028 RST SHALL asynchronously force state IDLE, TIM_1..3=0, prescaler=0, scan counter=0, OE_DIGIT=00, DIG_EN=110, RUNNING=0, OVF=0.
REQ-029 RST asserted mid-RUN SHALL abandon any pending tick; after release the block waits in IDLE for START_STOP.
REQ-030 Deassertion of RST SHALL only be timing-safe relative to CLK; no pulses are inferred from it.

Structure
REQ-031 State encodings and digit-select codes (00/01/10) SHALL live in the shared include timer_defs.vh, also used by the segment output stage.
REQ-032 One sub-module bcd_digit (4-bit BCD counter, inputs CLK, RST, CLR, CIN; outputs Q, COUT) SHALL be instantiated three times and chained.
REQ-033 Prescaler, scan counter and FSM SHALL reside in bcd_timer itself.

Verification (PRESCALE=4, SCAN_DIV=2)
REQ-034 Reset then one START_STOP -> RUNNING=1 next cycle; TIM_1 reads 1 after 4 more cycles, 2 after 8.
REQ-035 Run 40 ticks -> TIM_3,TIM_2,TIM_1 = 0,4,0; carry 9->10 observed with no digit >9.
REQ-036 START_STOP after 2 prescaler cycles, wait 20 cycles, START_STOP -> digits frozen during pause; next tick 2 cycles after resume.
REQ-037 Preload to 998 by running, run 2 ticks -> 000 with OVF=1; CLEAR -> OVF=0, state IDLE.
REQ-038 CLEAR and START_STOP same cycle while RUN -> IDLE, digits 000, RUNNING=0.
REQ-039 Free-run 12 cycles -> OE_DIGIT sequence 00,01,10,00,... changing every 2 cycles, DIG_EN matching, never 11; RST mid-sequence -> OE_DIGIT=00, DIG_EN=110 immediately.
